config_chain_loader: RTL and testbench
======================================

Name: config_chain_loader

Overview:
- Upstream feeder for the fabric configuration chain that drives the select inputs of the routing multiplexers and LUTs.
- Accepts bitstream words over a valid/ready handshake.
- Serializes each word LSB-first onto the chain while asserting the chain shift enable.
- Counts exactly CHAIN_LENGTH bits, then flags completion.

Parameters:
- DATA_WIDTH, 8, width of bitstream words on data_in.
- CHAIN_LENGTH, 64, total configuration bits in the downstream chain; must be >= 1.
- COUNT_WIDTH, 16, width of the internal bit counter; must satisfy 2^COUNT_WIDTH > CHAIN_LENGTH.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- nreset  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a load.
- data_in  input  DATA_WIDTH  bitstream word.
- data_valid  input  1  data_in is valid.
- data_ready  output  1  loader accepts a word this cycle.
- config_enable  output  1  chain shifts on the next rising edge of clock when high.
- config_out  output  1  serial bit presented to the chain head.
- busy  output  1  high in LOAD, SHIFT and CHECK.
- done  output  1  level; high once the chain is fully loaded.
- error  output  1  level; CRC mismatch flag (see Optional Feature).

Behaviour:
- Reset (asynchronous, nreset low):
  - State = IDLE.
  - Bit counter = 0, shift register = 0.
  - All outputs 0: data_ready, config_enable, config_out, busy, done, error.
- States: IDLE, LOAD, SHIFT, DONE (plus CHECK when CONFIG_CRC_EN is defined).
- Outputs are Moore, decoded from registered state and the shift register:
  - data_ready = (state == LOAD) or (state == CHECK).
  - config_enable = (state == SHIFT).
  - config_out = shreg[0] in SHIFT, else 0.
- IDLE or DONE, start = 1:
  - Clear bit counter, done and error; go to LOAD.
  - start in any other state is ignored.
- LOAD:
  - On data_valid & data_ready, capture data_in into shreg, clear the word-bit counter, go to SHIFT.
  - data_valid low stalls indefinitely with no chain activity.
- SHIFT (one bit per cycle):
  - shreg shifts right; word-bit counter and total bit counter increment.
  - If the total count reaches CHAIN_LENGTH on this bit, go to DONE (or CHECK with CRC). Any remaining bits of the current word are discarded.
  - Else, if DATA_WIDTH bits of this word are shifted, go to LOAD.
  - Else remain in SHIFT.
- Throughput and latency:
  - DATA_WIDTH SHIFT cycles per word plus at least one LOAD cycle.
  - First config_enable occurs on the cycle after the handshake.
- DONE: done = 1, busy = 0; hold until start or reset.
- Boundary conditions:
  - config_enable is asserted for exactly CHAIN_LENGTH cycles per load, never more.
  - The count never wraps within a load.
  - When CHAIN_LENGTH is not a multiple of DATA_WIDTH, the final word is partially consumed.
- Reset mid-operation: immediate return to IDLE with outputs as above. Chain contents are undefined and software must reload.

Optional Feature:
- Macro: CONFIG_CRC_EN.
- Defined:
  - A bit-serial CRC-8 (polynomial 0x07, init 0x00) is updated on every config_enable cycle using config_out, in shift order: fb = crc[7]^bit; crc = {crc[6:0],1'b0} ^ (fb ? 8'h07 : 8'h00).
  - The CRC is cleared on start.
  - After the final chain bit the FSM enters CHECK with data_ready = 1 and config_enable = 0.
  - On handshake, error <= (data_in[7:0] != crc), done <= 1, go to DONE.
  - Requires DATA_WIDTH >= 8.
- Not defined: no CHECK state, no CRC logic, error tied to 0, no trailing word consumed.

Test Plan:
- CHAIN_LENGTH=20, DATA_WIDTH=8; start, then words 0xA5, 0x3C, 0x0F with data_valid always high
  -> config_out during config_enable = 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1.
  -> Exactly 20 enable cycles; done rises the cycle after the 20th bit; upper nibble of 0x0F is dropped.
- Same load with data_valid low for 5 cycles before the second word
  -> data_ready = 1 and config_enable = 0 throughout the stall; identical bit sequence; done after 20 enables.
- start pulsed while in SHIFT on the second word
  -> ignored; sequence and done timing unchanged.
- nreset asserted on the 5th SHIFT cycle
  -> all outputs 0 immediately; state IDLE.
  -> A following start with 0xFF, 0xFF, 0xFF yields 20 ones and done.
- Back-to-back loads: start in DONE
  -> done clears the next cycle; second load completes normally.
- CONFIG_CRC_EN defined: after 20 bits, send the model-computed CRC -> done = 1, error = 0.
  -> Send CRC ^ 0x01 -> done = 1, error = 1.
  -> No config_enable during CHECK.

Source files
------------

// File: rtl/config_chain_loader_if.sv
// config_chain_loader_if: valid/ready word handshake between a bitstream source and config_chain_loader.
interface config_chain_loader_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] data_in;
   logic                  data_valid;
   logic                  data_ready;
   modport master (output data_in, data_valid, input data_ready);
   modport slave  (input data_in, data_valid, output data_ready);
endinterface

// File: rtl/config_chain_loader.sv
// config_chain_loader: shifts handshake words LSB-first into the fabric config chain, exactly CHAIN_LENGTH bits.
// Defining CONFIG_CRC_EN adds a trailing CRC-8 word check (CHECK state, error flag).
module config_chain_loader #(
   parameter int DATA_WIDTH   = 8,
   parameter int CHAIN_LENGTH = 64,
   parameter int COUNT_WIDTH  = 16
) (
   input  logic                 clock,
   input  logic                 nreset,
   input  logic                 start,
   config_chain_loader_if.slave bus,
   output logic                 config_enable,
   output logic                 config_out,
   output logic                 busy,
   output logic                 done,
   output logic                 error
);
   localparam int WW = $clog2(DATA_WIDTH + 1);
`ifdef CONFIG_CRC_EN
   typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DONE, CHECK} state_t;
`else
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
`endif
   state_t                  state_q, state_d;
   logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [WW-1:0]           wcnt_q, wcnt_d;
   logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
   logic                    done_q, done_d;
`ifdef CONFIG_CRC_EN
   logic [7:0]              crc_q, crc_d;
   logic                    error_q, error_d;
   assign bus.data_ready = (state_q == LOAD) || (state_q == CHECK);
   assign busy           = (state_q == LOAD) || (state_q == SHIFT) || (state_q == CHECK);
   assign error          = error_q;
`else
   assign bus.data_ready = (state_q == LOAD);
   assign busy           = (state_q == LOAD) || (state_q == SHIFT);
   assign error          = 1'b0;
`endif
   assign config_enable = (state_q == SHIFT);
   assign config_out    = (state_q == SHIFT) ? shreg_q[0] : 1'b0;
   assign done          = done_q;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wcnt_d  = wcnt_q;
      shreg_d = shreg_q;
      done_d  = done_q;
`ifdef CONFIG_CRC_EN
      crc_d   = crc_q;
      error_d = error_q;
`endif
      case (state_q)
         IDLE, DONE: if (start) begin
            state_d = LOAD;
            cnt_d   = '0;
            done_d  = 1'b0;
`ifdef CONFIG_CRC_EN
            crc_d   = 8'h00;
            error_d = 1'b0;
`endif
         end
         LOAD: if (bus.data_valid) begin
            shreg_d = bus.data_in;
            wcnt_d  = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            shreg_d = shreg_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            wcnt_d  = wcnt_q + 1'b1;
`ifdef CONFIG_CRC_EN
            crc_d   = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ shreg_q[0]) ? 8'h07 : 8'h00);
`endif
            // The chain-length limit wins over the word boundary, dropping any unused word bits.
            if (cnt_d == COUNT_WIDTH'(CHAIN_LENGTH)) begin
`ifdef CONFIG_CRC_EN
               state_d = CHECK;
`else
               state_d = DONE;
               done_d  = 1'b1;
`endif
            end else if (wcnt_d == WW'(DATA_WIDTH)) begin
               state_d = LOAD;
            end
         end
`ifdef CONFIG_CRC_EN
         CHECK: if (bus.data_valid) begin
            error_d = (bus.data_in[7:0] != crc_q);
            done_d  = 1'b1;
            state_d = DONE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wcnt_q  <= '0;
         shreg_q <= '0;
         done_q  <= 1'b0;
`ifdef CONFIG_CRC_EN
         crc_q   <= 8'h00;
         error_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wcnt_q  <= wcnt_d;
         shreg_q <= shreg_d;
         done_q  <= done_d;
`ifdef CONFIG_CRC_EN
         crc_q   <= crc_d;
         error_q <= error_d;
`endif
      end
   end
endmodule

// File: tb/tb_config_chain_loader.sv
// tb_config_chain_loader: directed loads with a per-cycle bit-queue model of the chain loader (CHAIN_LENGTH=20).
module tb_config_chain_loader;
   localparam int DW = 8;
   localparam int CL = 20;
   localparam bit [0:19] LIT = 20'b1010_0101_0011_1100_1111;
   logic clock = 1'b0;
   logic nreset = 1'b0;
   logic start = 1'b0;
   logic config_enable, config_out, busy, done, error;
   int checks = 0;
   int errors = 0;
   bit exp_q[$];
   bit got_q[$];
   bit m_busy = 0, m_done = 0, m_err = 0, m_check = 0;
   int en_cnt = 0;
   logic [7:0] m_crc = 8'h00;

   config_chain_loader_if #(.DATA_WIDTH(DW)) bus ();

   config_chain_loader #(.DATA_WIDTH(DW), .CHAIN_LENGTH(CL), .COUNT_WIDTH(16)) dut (
      .clock(clock),
      .nreset(nreset),
      .start(start),
      .bus(bus.slave),
      .config_enable(config_enable),
      .config_out(config_out),
      .busy(busy),
      .done(done),
      .error(error)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [0:19] pack(input bit q[$]);
      logic [0:19] v;
      v = '0;
      for (int i = 0; i < 20 && i < q.size(); i++) v[i] = q[i];
      return v;
   endfunction

   // Model: the chain must see the first CL bits of the word stream, LSB-first, one per enable.
   always @(negedge clock) begin
      if (!nreset) begin
         chk("reset_outputs", {26'd0, busy, done, error, config_enable, config_out, bus.data_ready}, 32'd0);
         m_busy = 0; m_done = 0; m_err = 0; m_check = 0; en_cnt = 0;
         exp_q.delete();
      end else begin
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         chk("error", error, m_err);
         chk("ready_and_enable", bus.data_ready & config_enable, 0);
         chk("ready_outside_load", bus.data_ready & ~m_busy, 0);
         if (!config_enable) chk("out_when_disabled", config_out, 0);
         if (m_check) chk("enable_in_check", config_enable, 0);
         if (start && !m_busy) begin
            m_busy = 1; m_done = 0; m_err = 0; en_cnt = 0;
            got_q.delete();
         end else if (config_enable) begin
            if (exp_q.size() == 0) chk("spurious_enable", config_enable, 0);
            else begin
               chk("config_out", config_out, exp_q.pop_front());
               got_q.push_back(config_out);
               en_cnt++;
               if (exp_q.size() == 0) begin
                  chk("enable_count", en_cnt, CL);
`ifdef CONFIG_CRC_EN
                  m_check = 1;
`else
                  m_busy = 0;
                  m_done = 1;
`endif
               end
            end
         end
`ifdef CONFIG_CRC_EN
         else if (m_check && bus.data_valid && bus.data_ready) begin
            m_check = 0; m_busy = 0; m_done = 1;
            m_err = (bus.data_in[7:0] != m_crc);
         end
`endif
      end
   end

   task automatic begin_load(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2);
      logic [23:0] s;
      logic [7:0] c;
      s = {w2, w1, w0};
      c = 8'h00;
      exp_q.delete();
      for (int i = 0; i < CL; i++) begin
         exp_q.push_back(s[i]);
         c = {c[6:0], 1'b0} ^ ((c[7] ^ s[i]) ? 8'h07 : 8'h00);
      end
      m_crc = c;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] w, input int stall);
      int n;
      n = 0;
      while (!bus.data_ready) begin
         if (n++ == 100) begin
            chk("ready_timeout", bus.data_ready, 1);
            return;
         end
         @(posedge clock); #1;
      end
      repeat (stall) begin
         chk("stall_ready", bus.data_ready, 1);
         chk("stall_enable", config_enable, 0);
         @(posedge clock); #1;
      end
      bus.data_in = w;
      bus.data_valid = 1'b1;
      @(posedge clock); #1;
      bus.data_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      chk("done_reached", done, 1);
      repeat (3) @(posedge clock);
      #1;
   endtask

   task automatic run_load(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                           input int stall, input bit poke, input logic [7:0] flip);
      begin_load(w0, w1, w2);
      pulse_start();
      send_word(w0, 0);
      send_word(w1, stall);
      if (poke) begin
         chk("poke_in_shift", config_enable, 1);
         pulse_start();
      end
      send_word(w2, 0);
`ifdef CONFIG_CRC_EN
      send_word(m_crc ^ flip, 0);
`endif
      wait_done();
   endtask

   initial begin
      bus.data_in = '0;
      bus.data_valid = 1'b0;
      #2;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_ready", bus.data_ready, 0);
      repeat (2) @(posedge clock);
      #1 nreset = 1'b1;
      @(posedge clock); #1;
      // plain load, model pinned to the hand-derived bit sequence
      begin_load(8'hA5, 8'h3C, 8'h0F);
      chk("model_pin_bits", pack(exp_q), LIT);
`ifdef CONFIG_CRC_EN
      chk("model_pin_crc", m_crc, 8'hD7);
`endif
      run_load(8'hA5, 8'h3C, 8'h0F, 0, 0, 8'h00);
      chk("seq_plain", pack(got_q), LIT);
      chk("count_plain", got_q.size(), CL);
      chk("error_plain", error, 0);
      // stall before the second word
      run_load(8'hA5, 8'h3C, 8'h0F, 5, 0, 8'h00);
      chk("seq_stall", pack(got_q), LIT);
      // start poked during SHIFT of the second word
      run_load(8'hA5, 8'h3C, 8'h0F, 0, 1, 8'h00);
      chk("seq_poke", pack(got_q), LIT);
      // reset on the fifth SHIFT cycle
      begin_load(8'hA5, 8'h3C, 8'h0F);
      pulse_start();
      send_word(8'hA5, 0);
      repeat (4) @(posedge clock);
      #1;
      chk("fifth_shift_enable", config_enable, 1);
      nreset = 1'b0;
      #1;
      chk("midreset_enable", config_enable, 0);
      chk("midreset_busy", busy, 0);
      chk("midreset_out", config_out, 0);
      chk("midreset_ready", bus.data_ready, 0);
      @(posedge clock); #1;
      nreset = 1'b1;
      @(posedge clock); #1;
      run_load(8'hFF, 8'hFF, 8'hFF, 0, 0, 8'h00);
      chk("seq_ones", pack(got_q), 20'hFFFFF);
      // back-to-back: start while in DONE
      begin_load(8'h5A, 8'hC3, 8'h81);
      pulse_start();
      chk("done_clears", done, 0);
      chk("busy_after_restart", busy, 1);
      send_word(8'h5A, 0);
      send_word(8'hC3, 0);
      send_word(8'h81, 0);
`ifdef CONFIG_CRC_EN
      send_word(m_crc, 0);
`endif
      wait_done();
      chk("seq_b2b", pack(got_q), 20'b0101_1010_1100_0011_1000);
`ifdef CONFIG_CRC_EN
      chk("crc_good_error", error, 0);
      run_load(8'hA5, 8'h3C, 8'h0F, 0, 0, 8'h01);
      chk("crc_bad_done", done, 1);
      chk("crc_bad_error", error, 1);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
